matrix_mul_ctrl: RTL and testbench

- Sequencer for the matrix-multiply datapath: computes C = A x B for square DIM x DIM matrices by time-sharing one multiply-accumulate unit.
- Generates A/B read addresses, accumulator clear/enable and C write strobes.
- Holds its state in a 3-bit state register that supports an operation-clear.
- Sits between the top-level command interface (start/clear) and the operand/result register files plus the MAC.

---
 rtl/matrix_mul_ctrl.sv | 110 +++++++++++
 tb/tb_matrix_mul_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_mul_ctrl.sv
// Sequencer for a single-MAC matrix multiplier: walks i/j/k over DIM x DIM
// operands, producing A/B read addresses, accumulator control and C write strobes.
module matrix_mul_ctrl #(
  parameter int DIM = 3,
  parameter int AW  = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          op_start,
  input  logic          op_clear,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic [AW-1:0] c_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          c_we,
  output logic          busy,
  output logic          done,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_CLR   = 3'b001,
    S_MAC   = 3'b010,
    S_WRITE = 3'b011,
    S_DONE  = 3'b100
  } state_t;

  localparam int            CW    = 3;
  localparam logic [CW-1:0] LAST  = CW'(DIM - 1);
  localparam logic [AW-1:0] DIM_A = AW'(DIM);

  state_t        st;
  logic [CW-1:0] i_q;
  logic [CW-1:0] j_q;
  logic [CW-1:0] k_q;

  // op_clear outranks every transition, including a start seen in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st  <= S_IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (op_clear) begin
      st  <= S_IDLE;
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          i_q <= '0;
          j_q <= '0;
          k_q <= '0;
          if (op_start) st <= S_CLR;
        end
        S_CLR: begin
          k_q <= '0;
          st  <= S_MAC;
        end
        S_MAC: begin
          if (k_q == LAST) begin
            k_q <= '0;
            st  <= S_WRITE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_WRITE: begin
          if (j_q != LAST) begin
            j_q <= j_q + 1'b1;
            st  <= S_CLR;
          end else if (i_q != LAST) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
            st  <= S_CLR;
          end else begin
            st <= S_DONE;
          end
        end
        S_DONE: begin
          i_q <= '0;
          j_q <= '0;
          k_q <= '0;
          st  <= S_IDLE;
        end
        default: begin
          i_q <= '0;
          j_q <= '0;
          k_q <= '0;
          st  <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes so operands line up with zero-latency reads.
  assign a_addr  = AW'(i_q) * DIM_A + AW'(k_q);
  assign b_addr  = AW'(k_q) * DIM_A + AW'(j_q);
  assign c_addr  = AW'(i_q) * DIM_A + AW'(j_q);
  assign mac_clr = (st == S_CLR);
  assign mac_en  = (st == S_MAC);
  assign c_we    = (st == S_WRITE);
  assign busy    = (st == S_CLR) || (st == S_MAC) || (st == S_WRITE);
  assign done    = (st == S_DONE);
  assign state   = st;

endmodule

// File: tb/tb_matrix_mul_ctrl.sv
// Directed bench for matrix_mul_ctrl at DIM=3: full runs, ignored start,
// abort, start/clear collision and asynchronous reset.
module tb_matrix_mul_ctrl;

  localparam int DIM = 3;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          op_start = 1'b0;
  logic          op_clear = 1'b0;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [AW-1:0] c_addr;
  logic          mac_clr;
  logic          mac_en;
  logic          c_we;
  logic          busy;
  logic          done;
  logic [2:0]    state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [AW-1:0] exp_q[$];

  matrix_mul_ctrl #(.DIM(DIM), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
    .mac_clr(mac_clr), .mac_en(mac_en), .c_we(c_we),
    .busy(busy), .done(done), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] outs;
    #12;
    outs = {state, a_addr, b_addr, c_addr, mac_clr, mac_en, c_we, busy, done};
    tests_run++;
    if (outs !== 20'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      tests_run++;
      if (state !== 3'b000 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle_hold: cycle %0d state=%b busy=%b expected state=000 busy=0", c, state, busy);
      end
    end
    // Start, then reset asynchronously in the middle of the MAC phase.
    op_start = 1'b1;
    step();
    op_start = 1'b0;
    step();
    step();
    tests_run++;
    if (state !== 3'b010) begin
      tests_failed++;
      $display("FAIL reset_pre_mac: state=%b expected 010", state);
    end
    #2 reset_n = 1'b0;
    #1;
    outs = {state, a_addr, b_addr, c_addr, mac_clr, mac_en, c_we, busy, done};
    tests_run++;
    if (outs !== 20'd0) begin
      tests_failed++;
      $display("FAIL reset_async_mid: got %h expected 0", outs);
    end
    @(negedge clk) reset_n = 1'b1;
    step();
  endtask

  // Full DIM=3 run from IDLE; optionally pokes op_start during element 2 MAC.
  task automatic test_full_run(input string name, input bit poke_start);
    logic [2:0] exp_ctl;
    logic [2:0] got_ctl;
    logic [AW-1:0] exp_addr;
    int ea[3];
    int eb[3];
    ea = '{3, 4, 5};
    eb = '{2, 5, 8};
    exp_q.delete();
    for (int e = 0; e < DIM * DIM; e++) exp_q.push_back(AW'(e));
    op_start = 1'b1;
    step();
    op_start = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      exp_ctl[2] = (c <= 45);
      exp_ctl[1] = (c <= 45) && ((c - 1) % 5 == 4);
      exp_ctl[0] = (c == 46);
      got_ctl = {busy, c_we, done};
      tests_run++;
      if (got_ctl !== exp_ctl) begin
        tests_failed++;
        $display("FAIL %s ctl: cycle %0d busy/c_we/done=%b expected %b", name, c, got_ctl, exp_ctl);
      end
      if (c_we === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL %s c_addr: cycle %0d extra write to %0d, none expected", name, c, c_addr);
        end else begin
          exp_addr = exp_q.pop_front();
          if (c_addr !== exp_addr) begin
            tests_failed++;
            $display("FAIL %s c_addr: cycle %0d got %0d expected %0d", name, c, c_addr, exp_addr);
          end
        end
      end
      if (c >= 27 && c <= 29) begin
        tests_run++;
        if (mac_en !== 1'b1 || a_addr !== AW'(ea[c-27]) || b_addr !== AW'(eb[c-27])) begin
          tests_failed++;
          $display("FAIL %s elem5_operands: cycle %0d mac_en=%b a=%0d b=%0d expected 1 a=%0d b=%0d",
                   name, c, mac_en, a_addr, b_addr, ea[c-27], eb[c-27]);
        end
      end
      if (poke_start) op_start = (c == 12 || c == 13);
      step();
    end
    op_start = 1'b0;
    tests_run++;
    if (exp_q.size() != 0 || state !== 3'b000) begin
      tests_failed++;
      $display("FAIL %s end: %0d writes missing, state=%b expected 0 missing, state=000",
               name, exp_q.size(), state);
    end
  endtask

  task automatic test_ignored_start();
    test_full_run("ignored_start", 1'b1);
  endtask

  task automatic test_abort();
    int we_cnt;
    int late_evt;
    we_cnt = 0;
    late_evt = 0;
    op_start = 1'b1;
    step();
    op_start = 1'b0;
    for (int c = 1; c < 23; c++) begin
      if (c_we === 1'b1) we_cnt++;
      step();
    end
    tests_run++;
    if (state !== 3'b010 || c_addr !== AW'(4) || we_cnt != 4) begin
      tests_failed++;
      $display("FAIL abort_pre: state=%b c_addr=%0d writes=%0d expected 010 4 4", state, c_addr, we_cnt);
    end
    op_clear = 1'b1;
    step();
    op_clear = 1'b0;
    tests_run++;
    if (state !== 3'b000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_idle: state=%b busy=%b expected 000 0", state, busy);
    end
    for (int c = 0; c < 50; c++) begin
      if (c_we === 1'b1 || done === 1'b1 || busy === 1'b1) late_evt++;
      step();
    end
    tests_run++;
    if (late_evt != 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: %0d active cycles after abort, expected 0", late_evt);
    end
    test_full_run("abort_restart", 1'b0);
  endtask

  task automatic test_simultaneous();
    op_start = 1'b1;
    op_clear = 1'b1;
    step();
    op_clear = 1'b0;
    tests_run++;
    if (state !== 3'b000) begin
      tests_failed++;
      $display("FAIL simul_clear_wins: state=%b expected 000", state);
    end
    step();
    op_start = 1'b0;
    tests_run++;
    if (state !== 3'b001 || mac_clr !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_start_next: state=%b mac_clr=%b expected 001 1", state, mac_clr);
    end
    op_clear = 1'b1;
    step();
    op_clear = 1'b0;
    tests_run++;
    if (state !== 3'b000) begin
      tests_failed++;
      $display("FAIL simul_cleanup: state=%b expected 000", state);
    end
  endtask

  task automatic test_reset_mid();
    op_start = 1'b1;
    step();
    op_start = 1'b0;
    for (int c = 1; c < 40; c++) step();
    tests_run++;
    if (state !== 3'b011 || c_we !== 1'b1 || c_addr !== AW'(7)) begin
      tests_failed++;
      $display("FAIL rst_mid_write: state=%b c_we=%b c_addr=%0d expected 011 1 7", state, c_we, c_addr);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (state !== 3'b000 || c_we !== 1'b0 || busy !== 1'b0 || c_addr !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: state=%b c_we=%b busy=%b c_addr=%0d expected 000 0 0 0",
               state, c_we, busy, c_addr);
    end
    @(negedge clk) reset_n = 1'b1;
    step();
    test_full_run("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_run("full_run", 1'b0);
    test_ignored_start();
    test_abort();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
